// File: rtl/jtag_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jtag_mem_ctrl_pkg
//  Brief    : Flag bit positions and controller state encoding for jtag_mem_ctrl
//  Revision : 1.0
// ============================================================================
package jtag_mem_ctrl_pkg;

    localparam int c_flag_autoinc = 0;
    localparam int c_flag_fill    = 1;
    localparam int c_flag_clr_err = 2;
    localparam int c_fill_cnt_lsb = 16;
    localparam int c_fill_cnt_w   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FILL  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/jtag_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : jtag_sync_edge
//  Brief    : 2-FF synchronizer with rising-edge detect for tck-domain strobes
//  Revision : 1.0
// ============================================================================
module jtag_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign pulse = r_sync & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/jtag_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : jtag_mem_ctrl
//  Brief    : Arbitrates one RAM port between JTAG-driven writes/fills and a
//             continuous read refresh of rdata_out
//  Revision : 1.0
// ============================================================================
module jtag_mem_ctrl
    import jtag_mem_ctrl_pkg::*;
#(
    parameter int DR_LENGTH  = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wram_enable,
    input  logic [DR_LENGTH-1:0]  waddr_in,
    input  logic [DR_LENGTH-1:0]  wdata_in,
    input  logic [DR_LENGTH-1:0]  raddr_in,
    input  logic [DR_LENGTH-1:0]  flags_in,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DR_LENGTH-1:0]  ram_wdata,
    output logic                  ram_we,
    input  logic [DR_LENGTH-1:0]  ram_rdata,
    output logic [DR_LENGTH-1:0]  rdata_out,
    output logic                  busy,
    output logic                  overrun
);

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    w_wr_req;
    logic                    w_accept;
    logic [ADDR_WIDTH-1:0]   w_waddr;
    logic [ADDR_WIDTH-1:0]   w_base;
    logic [c_fill_cnt_w-1:0] w_cnt;
    logic [ADDR_WIDTH-1:0]   r_wptr;
    logic [ADDR_WIDTH-1:0]   r_shadow;
    logic                    r_shadow_valid;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DR_LENGTH-1:0]    r_wdata;
    logic [c_fill_cnt_w-1:0] r_left;
    logic                    r_autoinc;
    logic                    r_overrun;
    logic                    r_rd_valid;
    logic [DR_LENGTH-1:0]    r_rdata;
    logic [ADDR_WIDTH-1:0]   r_raddr_q1;
    logic [ADDR_WIDTH-1:0]   r_raddr_q2;
    logic [ADDR_WIDTH-1:0]   r_raddr_s;
    logic                    w_ram_we;
    logic                    w_busy;
    logic [ADDR_WIDTH-1:0]   w_ram_addr;
    logic [DR_LENGTH-1:0]    w_ram_wdata;
    logic                    w_unused;

    jtag_sync_edge u_sync_wr (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (wram_enable),
        .pulse (w_wr_req)
    );

    assign w_waddr  = waddr_in[ADDR_WIDTH-1:0];
    assign w_cnt    = flags_in[c_fill_cnt_lsb +: c_fill_cnt_w];
    assign w_accept = w_wr_req && (r_state == ST_IDLE);
    // Re-strobing the same address continues from the write pointer.
    assign w_base   = (!r_shadow_valid || (w_waddr != r_shadow)) ? w_waddr : r_wptr;
    assign w_unused = &{1'b0, waddr_in, raddr_in, flags_in};

    always_comb begin
        w_state_next = r_state;
        w_ram_we     = 1'b0;
        w_busy       = 1'b0;
        w_ram_addr   = r_raddr_s;
        w_ram_wdata  = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_wr_req) begin
                    w_state_next = (flags_in[c_flag_fill] && (w_cnt != '0)) ? ST_FILL : ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_ram_we     = 1'b1;
                w_ram_addr   = r_addr;
                w_ram_wdata  = r_wdata;
                w_state_next = ST_IDLE;
            end
            ST_FILL: begin
                w_ram_we    = 1'b1;
                w_busy      = 1'b1;
                w_ram_addr  = r_addr;
                w_ram_wdata = r_wdata;
                if (r_left == c_fill_cnt_w'(1)) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_wptr         <= '0;
            r_shadow       <= '0;
            r_shadow_valid <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_left         <= '0;
            r_autoinc      <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_addr         <= w_base;
                r_wdata        <= wdata_in;
                r_left         <= w_cnt;
                r_autoinc      <= flags_in[c_flag_autoinc];
                r_shadow       <= w_waddr;
                r_shadow_valid <= 1'b1;
            end
            if (r_state == ST_WRITE) begin
                r_wptr <= r_autoinc ? (r_addr + ADDR_WIDTH'(1)) : r_addr;
            end
            if (r_state == ST_FILL) begin
                r_addr <= r_addr + ADDR_WIDTH'(1);
                r_left <= r_left - c_fill_cnt_w'(1);
                if (r_left == c_fill_cnt_w'(1)) begin
                    r_wptr <= r_addr + ADDR_WIDTH'(1);
                end
            end
            if (w_wr_req && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end else if (w_accept && flags_in[c_flag_clr_err]) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Raw read-address pipeline settles even while reset is held.
    always_ff @(posedge clk) begin
        r_raddr_q1 <= raddr_in[ADDR_WIDTH-1:0];
        r_raddr_q2 <= r_raddr_q1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_raddr_s  <= '0;
            r_rd_valid <= 1'b0;
            r_rdata    <= '0;
        end else begin
            if (r_raddr_q1 == r_raddr_q2) begin
                r_raddr_s <= r_raddr_q2;
            end
            // Only data from a read issued in IDLE is captured.
            r_rd_valid <= (r_state == ST_IDLE);
            if (r_rd_valid) begin
                r_rdata <= ram_rdata;
            end
        end
    end

    assign ram_addr  = w_ram_addr;
    assign ram_wdata = w_ram_wdata;
    assign ram_we    = w_ram_we;
    assign busy      = w_busy;
    assign rdata_out = r_rdata;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_jtag_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtag_mem_ctrl
//  Brief    : Directed self-checking bench for jtag_mem_ctrl with a RAM model
//  Revision : 1.0
// ============================================================================
module tb_jtag_mem_ctrl;

    logic        clk;
    logic        reset_n;
    logic        wram_enable;
    logic [31:0] waddr_in;
    logic [31:0] wdata_in;
    logic [31:0] raddr_in;
    logic [31:0] flags_in;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic [31:0] ram_rdata;
    logic [31:0] rdata_out;
    logic        busy;
    logic        overrun;

    bit   [31:0] mem [1024];
    logic        pl_en;
    logic [9:0]  pl_addr;
    logic [31:0] pl_data;

    logic [9:0]  q_addr[$];
    logic [31:0] q_data[$];
    int          we_run;
    int          max_run;
    int          busy_cnt;
    int          n_vec;
    int          n_err;

    jtag_mem_ctrl #(
        .DR_LENGTH  (32),
        .ADDR_WIDTH (10)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wram_enable (wram_enable),
        .waddr_in    (waddr_in),
        .wdata_in    (wdata_in),
        .raddr_in    (raddr_in),
        .flags_in    (flags_in),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_we      (ram_we),
        .ram_rdata   (ram_rdata),
        .rdata_out   (rdata_out),
        .busy        (busy),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (ram_we) begin
                q_addr.push_back(ram_addr);
                q_data.push_back(ram_wdata);
                we_run = we_run + 1;
                if (we_run > max_run) max_run = we_run;
            end else begin
                we_run = 0;
            end
            if (busy) busy_cnt = busy_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_data.delete();
        max_run  = 0;
        busy_cnt = 0;
    endtask

    task automatic strobe(input logic [31:0] a, input logic [31:0] d, input logic [31:0] f);
        waddr_in    = a;
        wdata_in    = d;
        flags_in    = f;
        wram_enable = 1'b1;
        repeat (4) @(negedge clk);
        wram_enable = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        logic [9:0] exp_fill [4];
        int         k;
        n_vec = 0; n_err = 0;
        we_run = 0; max_run = 0; busy_cnt = 0;
        reset_n = 1'b0; wram_enable = 1'b0;
        waddr_in = '0; wdata_in = '0; flags_in = '0; raddr_in = 32'd5;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;

        // Preload while reset is held
        @(negedge clk);
        pl_en = 1'b1; pl_addr = 10'd5; pl_data = 32'hA5A5_A5A5;
        @(negedge clk);
        pl_addr = 10'd6; pl_data = 32'h6666_6666;
        @(negedge clk);
        pl_en = 1'b0;
        @(negedge clk);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_rdata", rdata_out, 32'd0);
        check("rst_ram_wdata", ram_wdata, 32'd0);

        // 1: idle read refresh
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_rdata", rdata_out, 32'hA5A5_A5A5);
        check("idle_no_we", 32'(q_addr.size()), 32'd0);

        // 2: auto-increment writes
        clear_log();
        strobe(32'h10, 32'd1, 32'h1);
        strobe(32'h10, 32'd2, 32'h1);
        strobe(32'h10, 32'd3, 32'h1);
        check("ainc_count", 32'(q_addr.size()), 32'd3);
        check("ainc_pulse", 32'(max_run), 32'd1);
        check("ainc_m10", mem[10'h10], 32'd1);
        check("ainc_m11", mem[10'h11], 32'd2);
        check("ainc_m12", mem[10'h12], 32'd3);
        raddr_in = 32'h12;
        repeat (8) @(negedge clk);
        check("ainc_readback", rdata_out, 32'd3);

        // 3: fill across the address wrap
        clear_log();
        strobe(32'h3FE, 32'hDEAD, 32'h0004_0002);
        repeat (4) @(negedge clk);
        exp_fill[0] = 10'h3FE; exp_fill[1] = 10'h3FF;
        exp_fill[2] = 10'h000; exp_fill[3] = 10'h001;
        check("fill_count", 32'(q_addr.size()), 32'd4);
        check("fill_busy", 32'(busy_cnt), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("fill_addr", 32'(q_addr[i]), 32'(exp_fill[i]));
            check("fill_data", q_data[i], 32'hDEAD);
        end
        check("fill_busy_done", 32'(busy), 32'd0);
        clear_log();
        strobe(32'h3FE, 32'hBEEF, 32'h1);
        check("post_fill_addr", 32'(q_addr[0]), 32'h002);
        check("post_fill_m2", mem[10'h002], 32'hBEEF);

        // 4: strobe dropped during a fill
        clear_log();
        waddr_in = 32'h100; wdata_in = 32'h1111; flags_in = 32'h0008_0002;
        wram_enable = 1'b1;
        repeat (2) @(negedge clk);
        wram_enable = 1'b0;
        repeat (2) @(negedge clk);
        waddr_in = 32'h200; wdata_in = 32'h5555; flags_in = 32'h1;
        wram_enable = 1'b1;
        repeat (2) @(negedge clk);
        wram_enable = 1'b0;
        repeat (14) @(negedge clk);
        check("ovr_count", 32'(q_addr.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("ovr_fill_addr", 32'(q_addr[i]), 32'h100 + 32'(i));
        end
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_no_write", mem[10'h200], 32'd0);
        strobe(32'h200, 32'h7777, 32'h4);
        check("ovr_cleared", 32'(overrun), 32'd0);
        check("ovr_clr_write", mem[10'h200], 32'h7777);

        // 5: reset in the middle of a fill
        clear_log();
        waddr_in = 32'h300; wdata_in = 32'h1234; flags_in = 32'h0006_0002;
        wram_enable = 1'b1;
        k = 0;
        while (q_addr.size() < 2 && k < 20) begin
            @(posedge clk);
            #2;
            k = k + 1;
        end
        check("rstfill_reach", 32'(q_addr.size()), 32'd2);
        reset_n = 1'b0;
        #1;
        check("rstfill_we", 32'(ram_we), 32'd0);
        check("rstfill_busy", 32'(busy), 32'd0);
        wram_enable = 1'b0;
        repeat (4) @(negedge clk);
        check("rstfill_m300", mem[10'h300], 32'h1234);
        check("rstfill_m301", mem[10'h301], 32'h1234);
        check("rstfill_m302", mem[10'h302], 32'd0);
        check("rstfill_m305", mem[10'h305], 32'd0);
        check("rstfill_count", 32'(q_addr.size()), 32'd2);
        reset_n = 1'b1;

        // 6: one-cycle raddr glitches are filtered
        raddr_in = 32'd5;
        repeat (8) @(negedge clk);
        check("glitch_base", rdata_out, 32'hA5A5_A5A5);
        for (int i = 0; i < 12; i++) begin
            raddr_in = (i % 2 == 1) ? 32'd5 : 32'd6;
            @(negedge clk);
            check("glitch_hold", rdata_out, 32'hA5A5_A5A5);
        end
        raddr_in = 32'd6;
        repeat (8) @(negedge clk);
        check("glitch_settle", rdata_out, 32'h6666_6666);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
